// File: rtl/kernel_nios2_oci_trace_capture_pkg.sv
// Shared types and default widths for the OCI trace-capture buffer.
package kernel_nios2_oci_trace_capture_pkg;

  localparam int unsigned TRACE_DATA_W = 30;
  localparam int unsigned TRACE_CNT_W  = 4;
  localparam int unsigned TRACE_DEPTH  = 16;
  localparam int unsigned TRACE_TOT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CAPTURE = 2'b01,
    ST_DRAIN   = 2'b10,
    ST_DONE    = 2'b11
  } trace_state_e;

endpackage

// File: rtl/kernel_nios2_oci_trace_capture_if.sv
// Packet-capture strobe and valid/ready read port of the trace buffer.
interface kernel_nios2_oci_trace_capture_if
  import kernel_nios2_oci_trace_capture_pkg::*;
#(
  parameter int unsigned DATA_W = TRACE_DATA_W,
  parameter int unsigned CNT_W  = TRACE_CNT_W
) ();

  logic                      dct_valid;
  logic [DATA_W-1:0]         dct_buffer;
  logic [CNT_W-1:0]          dct_count;
  logic                      rd_ready;
  logic                      rd_valid;
  logic [CNT_W+DATA_W-1:0]   rd_data;

  modport master (
    output dct_valid, dct_buffer, dct_count, rd_ready,
    input  rd_valid, rd_data
  );

  modport slave (
    input  dct_valid, dct_buffer, dct_count, rd_ready,
    output rd_valid, rd_data
  );

endinterface

// File: rtl/kernel_nios2_oci_trace_capture_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port, array not reset.
module kernel_nios2_oci_trace_capture_ram #(
  parameter  int unsigned DEPTH  = 16,
  parameter  int unsigned WIDTH  = 34,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/kernel_nios2_oci_trace_capture.sv
// Circular trace-capture buffer with stop-on-full or wrap mode and an IDLE/CAPTURE/DRAIN/DONE
// test-end sequencer; contents drain over a show-ahead valid/ready port.
module kernel_nios2_oci_trace_capture
  import kernel_nios2_oci_trace_capture_pkg::*;
#(
  parameter  int unsigned DATA_W    = TRACE_DATA_W,
  parameter  int unsigned CNT_W     = TRACE_CNT_W,
  parameter  int unsigned DEPTH     = TRACE_DEPTH,
  parameter  bit          WRAP_MODE = 1'b1,
  parameter  int unsigned TOT_W     = TRACE_TOT_W,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned FILL_W    = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 arm,
  input  logic                 test_ending,
  input  logic                 test_has_ended,
  kernel_nios2_oci_trace_capture_if.slave bus,
  output logic [FILL_W-1:0]    fill_level,
  output logic                 overflow,
  output logic [1:0]           state_o,
  output logic                 drain_done,
  output logic [TOT_W-1:0]     total_count
);

  trace_state_e       state_q, state_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [TOT_W-1:0]   total_q, total_d;
  logic               overflow_q, overflow_d;
  logic               rd_valid_q, rd_valid_d;
  logic               drain_done_q, drain_done_d;
  logic               wr_qual, pop, full, push, lost, we;

  kernel_nios2_oci_trace_capture_ram #(
    .DEPTH (DEPTH),
    .WIDTH (CNT_W + DATA_W)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .waddr   (wr_ptr_q),
    .wdata   ({bus.dct_count, bus.dct_buffer}),
    .raddr   (rd_ptr_q),
    .rdata_c (bus.rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      total_q      <= '0;
      overflow_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      total_q      <= total_d;
      overflow_q   <= overflow_d;
      rd_valid_q   <= rd_valid_d;
      drain_done_q <= drain_done_d;
    end
  end

  // Next-state: pointer/fill bookkeeping first, then sequencer, with arm overriding everything.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    total_d    = total_q;
    overflow_d = overflow_q;

    wr_qual = (state_q == ST_CAPTURE) && bus.dct_valid && (bus.dct_count != '0);
    pop     = rd_valid_q && bus.rd_ready;
    full    = (fill_q == FILL_W'(DEPTH));
    push    = wr_qual && (!full || pop || WRAP_MODE);
    lost    = wr_qual && full && !pop;
    we      = push;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    // Overwrite in wrap mode retires the oldest entry along with the pop path.
    if (pop || (lost && WRAP_MODE)) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !full && !pop)      fill_d = fill_q + FILL_W'(1);
    else if (pop && !push)          fill_d = fill_q - FILL_W'(1);
    if (lost) overflow_d = 1'b1;
    if (wr_qual && (total_q != '1)) total_d = total_q + TOT_W'(1);

    case (state_q)
      ST_IDLE:    state_d = ST_IDLE;
      ST_CAPTURE: if (test_ending || test_has_ended) state_d = ST_DRAIN;
      ST_DRAIN:   if ((fill_d == '0) && test_has_ended) state_d = ST_DONE;
      ST_DONE:    state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase

    if (arm) begin
      state_d    = ST_CAPTURE;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fill_d     = '0;
      total_d    = '0;
      overflow_d = 1'b0;
      we         = 1'b0;
    end

    rd_valid_d   = (fill_d != '0) && (state_d != ST_IDLE);
    drain_done_d = (state_d == ST_DONE);
  end

  assign bus.rd_valid  = rd_valid_q;
  assign fill_level    = fill_q;
  assign overflow      = overflow_q;
  assign state_o       = state_q;
  assign drain_done    = drain_done_q;
  assign total_count   = total_q;

endmodule

// File: tb/tb_kernel_nios2_oci_trace_capture.sv
// Directed bench: a wrap-mode and a drop-mode instance driven by shared capture/control stimulus.
module tb_kernel_nios2_oci_trace_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        arm, test_ending, test_has_ended;
  logic        dct_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        rd_ready_w, rd_ready_n;

  logic [4:0]  fill_w, fill_n;
  logic        ovf_w, ovf_n, dd_w, dd_n;
  logic [1:0]  st_w, st_n;
  logic [31:0] tot_w, tot_n;

  int tests = 0;
  int fails = 0;

  kernel_nios2_oci_trace_capture_if #(.DATA_W(30), .CNT_W(4)) if_w ();
  kernel_nios2_oci_trace_capture_if #(.DATA_W(30), .CNT_W(4)) if_n ();

  assign if_w.dct_valid  = dct_valid;
  assign if_w.dct_buffer = dct_buffer;
  assign if_w.dct_count  = dct_count;
  assign if_w.rd_ready   = rd_ready_w;
  assign if_n.dct_valid  = dct_valid;
  assign if_n.dct_buffer = dct_buffer;
  assign if_n.dct_count  = dct_count;
  assign if_n.rd_ready   = rd_ready_n;

  kernel_nios2_oci_trace_capture #(.DATA_W(30), .CNT_W(4), .DEPTH(16), .WRAP_MODE(1'b1), .TOT_W(32)) dut_w (
    .clk(clk), .reset_n(reset_n), .arm(arm), .test_ending(test_ending),
    .test_has_ended(test_has_ended), .bus(if_w.slave), .fill_level(fill_w),
    .overflow(ovf_w), .state_o(st_w), .drain_done(dd_w), .total_count(tot_w)
  );

  kernel_nios2_oci_trace_capture #(.DATA_W(30), .CNT_W(4), .DEPTH(16), .WRAP_MODE(1'b0), .TOT_W(32)) dut_n (
    .clk(clk), .reset_n(reset_n), .arm(arm), .test_ending(test_ending),
    .test_has_ended(test_has_ended), .bus(if_n.slave), .fill_level(fill_n),
    .overflow(ovf_n), .state_o(st_n), .drain_done(dd_n), .total_count(tot_n)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; arm = 1'b0; test_ending = 1'b0; test_has_ended = 1'b0;
    dct_valid = 1'b0; dct_buffer = '0; dct_count = '0; rd_ready_w = 1'b0; rd_ready_n = 1'b0;
    step(); step();
    chk("rst_state", 64'(st_w), 64'd0);
    chk("rst_fill", 64'(fill_w), 64'd0);
    chk("rst_rd_valid", 64'(if_w.rd_valid), 64'd0);
    chk("rst_overflow", 64'(ovf_w), 64'd0);
    chk("rst_total", 64'(tot_w), 64'd0);
    chk("rst_drain_done", 64'(dd_w), 64'd0);
    reset_n = 1'b1;
    step();

    // Five packets, nothing read.
    do_arm();
    chk("t1_state", 64'(st_w), 64'd1);
    chk("t1_rv_empty", 64'(if_w.rd_valid), 64'd0);
    dct_valid = 1'b1; dct_count = 4'd3;
    for (int i = 0; i < 5; i++) begin
      dct_buffer = 30'h100 + 30'(i);
      step();
      if (i == 0) begin
        chk("t1_rv_first", 64'(if_w.rd_valid), 64'd1);
        chk("t1_fill_first", 64'(fill_w), 64'd1);
      end
    end
    dct_valid = 1'b0;
    chk("t1_fill", 64'(fill_w), 64'd5);
    chk("t1_rd_data", 64'(if_w.rd_data), 64'({4'd3, 30'h100}));
    chk("t1_overflow", 64'(ovf_w), 64'd0);

    // Twenty packets into sixteen entries, both modes.
    do_arm();
    dct_valid = 1'b1; dct_count = 4'd1;
    for (int i = 0; i < 20; i++) begin
      dct_buffer = 30'(i);
      step();
    end
    dct_valid = 1'b0;
    chk("t2_fill", 64'(fill_w), 64'd16);
    chk("t2_rd_data", 64'(if_w.rd_data), 64'({4'd1, 30'd4}));
    chk("t2_overflow", 64'(ovf_w), 64'd1);
    chk("t2_total", 64'(tot_w), 64'd20);
    chk("t3_fill", 64'(fill_n), 64'd16);
    chk("t3_overflow", 64'(ovf_n), 64'd1);
    chk("t3_total", 64'(tot_n), 64'd20);
    rd_ready_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t3_seq%0d", i), 64'(if_n.rd_data), 64'({4'd1, 30'(i)}));
      step();
    end
    rd_ready_n = 1'b0;
    chk("t3_fill_end", 64'(fill_n), 64'd0);
    chk("t3_rv_end", 64'(if_n.rd_valid), 64'd0);
    rd_ready_w = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t2_seq%0d", i), 64'(if_w.rd_data), 64'({4'd1, 30'(i + 4)}));
      step();
    end
    rd_ready_w = 1'b0;
    chk("t2_fill_end", 64'(fill_w), 64'd0);

    // Full buffer with simultaneous push and pop.
    do_arm();
    dct_valid = 1'b1; dct_count = 4'd2;
    for (int i = 0; i < 16; i++) begin
      dct_buffer = 30'h200 + 30'(i);
      step();
    end
    chk("t4_full", 64'(fill_w), 64'd16);
    rd_ready_w = 1'b1;
    for (int j = 0; j < 4; j++) begin
      dct_buffer = 30'h300 + 30'(j);
      step();
      chk($sformatf("t4_fill%0d", j), 64'(fill_w), 64'd16);
    end
    dct_valid = 1'b0;
    chk("t4_overflow", 64'(ovf_w), 64'd0);
    chk("t4_total", 64'(tot_w), 64'd20);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t4_seq%0d", i), 64'(if_w.rd_data),
          64'({4'd2, (i < 12) ? 30'h204 + 30'(i) : 30'h300 + 30'(i - 12)}));
      step();
    end
    rd_ready_w = 1'b0;
    chk("t4_fill_end", 64'(fill_w), 64'd0);

    // Empty packets are never stored or counted.
    do_arm();
    dct_valid = 1'b1; dct_count = 4'd0; dct_buffer = 30'h3ff;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t5_rv%0d", i), 64'(if_w.rd_valid), 64'd0);
    end
    chk("t5_fill", 64'(fill_w), 64'd0);
    chk("t5_total", 64'(tot_w), 64'd0);
    // Write into an empty buffer while the consumer is ready: no pop that cycle.
    rd_ready_w = 1'b1; dct_count = 4'd1; dct_buffer = 30'd7;
    step();
    dct_valid = 1'b0;
    chk("t5_wr_rd_fill", 64'(fill_w), 64'd1);
    chk("t5_wr_rd_data", 64'(if_w.rd_data), 64'({4'd1, 30'd7}));
    step();
    rd_ready_w = 1'b0;
    chk("t5_pop_fill", 64'(fill_w), 64'd0);

    // Arm wins over test_ending, then drain to DONE.
    arm = 1'b1; test_ending = 1'b1;
    step();
    arm = 1'b0; test_ending = 1'b0;
    chk("t6_arm_wins", 64'(st_w), 64'd1);
    dct_valid = 1'b1; dct_count = 4'd5;
    for (int i = 0; i < 3; i++) begin
      dct_buffer = 30'h40 + 30'(i);
      step();
    end
    dct_valid = 1'b0;
    test_ending = 1'b1; test_has_ended = 1'b1;
    step();
    test_ending = 1'b0;
    chk("t6_drain", 64'(st_w), 64'd2);
    chk("t6_fill3", 64'(fill_w), 64'd3);
    rd_ready_w = 1'b1;
    step();
    chk("t6_drain2", 64'(st_w), 64'd2);
    step();
    chk("t6_drain1", 64'(st_w), 64'd2);
    chk("t6_fill1", 64'(fill_w), 64'd1);
    step();
    chk("t6_done", 64'(st_w), 64'd3);
    chk("t6_drain_done", 64'(dd_w), 64'd1);
    chk("t6_fill0", 64'(fill_w), 64'd0);
    chk("t6_rv0", 64'(if_w.rd_valid), 64'd0);
    step();
    chk("t6_done_hold", 64'(st_w), 64'd3);
    rd_ready_w = 1'b0; test_has_ended = 1'b0;
    do_arm();
    chk("t6_rearm", 64'(st_w), 64'd1);
    chk("t6_rearm_fill", 64'(fill_w), 64'd0);
    chk("t6_rearm_dd", 64'(dd_w), 64'd0);

    // Asynchronous reset mid-capture discards contents.
    dct_valid = 1'b1; dct_count = 4'd1;
    step(); step();
    dct_valid = 1'b0;
    chk("t7_fill_pre", 64'(fill_w), 64'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("t7_fill_rst", 64'(fill_w), 64'd0);
    chk("t7_state_rst", 64'(st_w), 64'd0);
    chk("t7_rv_rst", 64'(if_w.rd_valid), 64'd0);
    step();
    reset_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
